// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with a per-register pending-producer
// scoreboard and optional same-cycle write-to-read bypass.
module regfile_sb #(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int NRP    = 2,
  parameter int BYPASS = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NRP*AW-1:0]     raddr,
  output logic [NRP*XLEN-1:0]   rdata,
  output logic [NRP-1:0]        rbusy,
  input  logic                  regwr,
  input  logic [AW-1:0]         rdaddr,
  input  logic [XLEN-1:0]       win,
  input  logic                  iss_valid,
  input  logic [AW-1:0]         iss_rd,
  output logic [(1<<AW)-1:0]    busy_vec
);

  localparam int NREGS = 1 << AW;

  if (NRP < 1 || NRP > 4) begin : g_bad_nrp
    $error("regfile_sb: NRP must be in the range 1..4");
  end

  logic [XLEN-1:0]  mem_q [NREGS];
  logic [XLEN-1:0]  mem_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [NREGS-1:0] wr_sel;
  logic [NREGS-1:0] iss_sel;

  // Register 0 is masked out of both one-hot selects, so it never changes.
  always_comb begin
    wr_sel          = '0;
    iss_sel         = '0;
    wr_sel[rdaddr]  = regwr;
    iss_sel[iss_rd] = iss_valid;
    wr_sel[0]       = 1'b0;
    iss_sel[0]      = 1'b0;
  end

  // Issue is applied after the write clear so a new producer keeps the bit set.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      mem_d[r] = wr_sel[r] ? win : mem_q[r];
    end
    busy_d = (busy_q & ~wr_sel) | iss_sel;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= '0;
      for (int r = 0; r < NREGS; r++) begin
        mem_q[r] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      mem_q  <= mem_d;
    end
  end

  assign busy_vec = busy_q;

  for (genvar i = 0; i < NRP; i++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd;
    logic            rb;

    assign ra = raddr[i*AW +: AW];

    // A matching write in flight overrides both the stored value and busy bit.
    always_comb begin
      if (ra == '0) begin
        rd = '0;
        rb = 1'b0;
      end else if ((BYPASS != 0) && regwr && (rdaddr == ra)) begin
        rd = win;
        rb = 1'b0;
      end else begin
        rd = mem_q[ra];
        rb = busy_q[ra];
      end
    end

    assign rdata[i*XLEN +: XLEN] = rd;
    assign rbusy[i]              = rb;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus a random phase
// against a behavioural register/scoreboard model, on three parameter sets.
module tb_regfile_sb;

  localparam int XL  = 32;
  localparam int AWD = 5;
  localparam int NP  = 2;
  localparam int NR  = 32;
  localparam int WXL = 64;
  localparam int WAW = 4;
  localparam int WNP = 4;
  localparam int WNR = 16;

  logic clk = 1'b0;
  logic rst_n;

  logic [NP*AWD-1:0] raddr;
  logic [NP*XL-1:0]  rdata, nb_rdata;
  logic [NP-1:0]     rbusy, nb_rbusy;
  logic              regwr;
  logic [AWD-1:0]    rdaddr;
  logic [XL-1:0]     win;
  logic              iss_valid;
  logic [AWD-1:0]    iss_rd;
  logic [NR-1:0]     busy_vec, nb_busy_vec;

  logic [WNP*WAW-1:0] w_raddr;
  logic [WNP*WXL-1:0] w_rdata;
  logic [WNP-1:0]     w_rbusy;
  logic               w_regwr;
  logic [WAW-1:0]     w_rdaddr;
  logic [WXL-1:0]     w_win;
  logic               w_iss_valid;
  logic [WAW-1:0]     w_iss_rd;
  logic [WNR-1:0]     w_busy_vec;

  int total = 0;
  int bad   = 0;

  logic [XL-1:0]  m_reg  [NR];
  logic [NR-1:0]  m_busy;
  logic [WXL-1:0] wm_reg [WNR];
  logic [WNR-1:0] wm_busy;

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(XL), .AW(AWD), .NRP(NP), .BYPASS(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .regwr(regwr), .rdaddr(rdaddr), .win(win), .iss_valid(iss_valid),
    .iss_rd(iss_rd), .busy_vec(busy_vec));

  regfile_sb #(.XLEN(XL), .AW(AWD), .NRP(NP), .BYPASS(0)) u_nb (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(nb_rdata), .rbusy(nb_rbusy),
    .regwr(regwr), .rdaddr(rdaddr), .win(win), .iss_valid(iss_valid),
    .iss_rd(iss_rd), .busy_vec(nb_busy_vec));

  regfile_sb #(.XLEN(WXL), .AW(WAW), .NRP(WNP), .BYPASS(1)) u_wide (
    .clk(clk), .rst_n(rst_n), .raddr(w_raddr), .rdata(w_rdata), .rbusy(w_rbusy),
    .regwr(w_regwr), .rdaddr(w_rdaddr), .win(w_win), .iss_valid(w_iss_valid),
    .iss_rd(w_iss_rd), .busy_vec(w_busy_vec));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [XL-1:0] exp_rd(input logic [AWD-1:0] a, input bit byp);
    if (a == 5'd0) return 32'd0;
    if (byp && regwr && rdaddr == a) return win;
    return m_reg[a];
  endfunction

  function automatic logic exp_bz(input logic [AWD-1:0] a, input bit byp);
    if (a == 5'd0) return 1'b0;
    if (byp && regwr && rdaddr == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic [WXL-1:0] w_exp_rd(input logic [WAW-1:0] a);
    if (a == 4'd0) return 64'd0;
    if (w_regwr && w_rdaddr == a) return w_win;
    return wm_reg[a];
  endfunction

  function automatic logic w_exp_bz(input logic [WAW-1:0] a);
    if (a == 4'd0) return 1'b0;
    if (w_regwr && w_rdaddr == a) return 1'b0;
    return wm_busy[a];
  endfunction

  // Reference update for one clock edge: reset wipes all, write clears busy, issue sets it.
  task automatic model_edge();
    if (!rst_n) begin
      for (int r = 0; r < NR; r++) m_reg[r] = 32'd0;
      for (int r = 0; r < WNR; r++) wm_reg[r] = 64'd0;
      m_busy  = '0;
      wm_busy = '0;
    end else begin
      if (regwr && rdaddr != 5'd0) begin
        m_reg[rdaddr]  = win;
        m_busy[rdaddr] = 1'b0;
      end
      if (iss_valid && iss_rd != 5'd0) m_busy[iss_rd] = 1'b1;
      if (w_regwr && w_rdaddr != 4'd0) begin
        wm_reg[w_rdaddr]  = w_win;
        wm_busy[w_rdaddr] = 1'b0;
      end
      if (w_iss_valid && w_iss_rd != 4'd0) wm_busy[w_iss_rd] = 1'b1;
    end
  endtask

  task automatic check_all();
    logic [AWD-1:0] a;
    logic [WAW-1:0] wa;
    for (int p = 0; p < NP; p++) begin
      a = raddr[p*AWD +: AWD];
      chk($sformatf("rdata%0d_a%0d", p, a), rdata[p*XL +: XL], exp_rd(a, 1'b1));
      chk($sformatf("rbusy%0d_a%0d", p, a), rbusy[p], exp_bz(a, 1'b1));
      chk($sformatf("nb_rdata%0d_a%0d", p, a), nb_rdata[p*XL +: XL], exp_rd(a, 1'b0));
      chk($sformatf("nb_rbusy%0d_a%0d", p, a), nb_rbusy[p], exp_bz(a, 1'b0));
    end
    chk("busy_vec", busy_vec, m_busy);
    chk("nb_busy_vec", nb_busy_vec, m_busy);
    for (int p = 0; p < WNP; p++) begin
      wa = w_raddr[p*WAW +: WAW];
      chk($sformatf("w_rdata%0d_a%0d", p, wa), w_rdata[p*WXL +: WXL], w_exp_rd(wa));
      chk($sformatf("w_rbusy%0d_a%0d", p, wa), w_rbusy[p], w_exp_bz(wa));
    end
    chk("w_busy_vec", w_busy_vec, wm_busy);
  endtask

  task automatic settle_check();
    #1;
    check_all();
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic sweep();
    regwr     = 1'b0;
    iss_valid = 1'b0;
    for (int a = 0; a < NR; a++) begin
      raddr = {5'(NR - 1 - a), 5'(a)};
      settle_check();
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0; raddr = '0; regwr = 1'b0; rdaddr = '0; win = '0;
    iss_valid = 1'b0; iss_rd = '0;
    w_raddr = '0; w_regwr = 1'b0; w_rdaddr = '0; w_win = '0;
    w_iss_valid = 1'b0; w_iss_rd = '0;
    tick();
    rst_n = 1'b1;
    settle_check();
    chk("reset_busy_vec", busy_vec, 64'd0);

    // Fill r1..r31, issuing r5 alongside the last write.
    for (int r = 1; r < NR; r++) begin
      regwr = 1'b1; rdaddr = 5'(r); win = 32'hA5A5_0000 + 32'(r);
      iss_valid = (r == NR - 1); iss_rd = 5'd5;
      raddr = {5'd1, 5'(r)};
      settle_check();
      tick();
    end
    sweep();
    chk("fill_busy_r5", busy_vec, 64'h20);

    // Reset with a concurrent write that must be discarded.
    rst_n = 1'b0; regwr = 1'b1; rdaddr = 5'd4; win = 32'hDEAD_0004;
    iss_valid = 1'b1; iss_rd = 5'd6;
    settle_check();
    tick();
    rst_n = 1'b1;
    sweep();
    raddr = {5'd5, 5'd4};
    settle_check();
    chk("reset_r4_dropped", rdata[31:0], 64'd0);
    chk("reset_busy_clear", busy_vec, 64'd0);
    tick();

    // Same-cycle bypass of r7.
    regwr = 1'b1; rdaddr = 5'd7; win = 32'hDEADBEEF; raddr = {5'd0, 5'd7};
    settle_check();
    chk("byp_same_cycle", rdata[31:0], 64'hDEADBEEF);
    chk("nobyp_old_value", nb_rdata[31:0], 64'd0);
    tick();
    regwr = 1'b0;
    settle_check();
    chk("byp_next_cycle", rdata[31:0], 64'hDEADBEEF);
    chk("nobyp_next_cycle", nb_rdata[31:0], 64'hDEADBEEF);

    // Register 0 ignores writes and issues.
    regwr = 1'b1; rdaddr = 5'd0; win = 32'hFFFF_FFFF;
    iss_valid = 1'b1; iss_rd = 5'd0; raddr = {5'd0, 5'd0};
    settle_check();
    chk("r0_same_cycle", rdata[31:0], 64'd0);
    tick();
    regwr = 1'b0; iss_valid = 1'b0;
    settle_check();
    chk("r0_busy", busy_vec[0], 64'd0);
    chk("r0_data", rdata[31:0], 64'd0);

    // Scoreboard: issue r3, then its write clears busy via bypass.
    iss_valid = 1'b1; iss_rd = 5'd3; raddr = {5'd3, 5'd0};
    settle_check();
    tick();
    iss_valid = 1'b0;
    settle_check();
    chk("sb_rbusy_r3", rbusy[1], 64'd1);
    chk("sb_busy_vec_r3", busy_vec, 64'h8);
    regwr = 1'b1; rdaddr = 5'd3; win = 32'h12;
    settle_check();
    chk("sb_byp_rbusy", rbusy[1], 64'd0);
    chk("sb_byp_rdata", rdata[63:32], 64'h12);
    chk("sb_nobyp_rbusy", nb_rbusy[1], 64'd1);
    tick();
    regwr = 1'b0;
    settle_check();
    chk("sb_cleared", busy_vec, 64'd0);

    // Simultaneous issue and write to a busy r9.
    iss_valid = 1'b1; iss_rd = 5'd9;
    settle_check();
    tick();
    regwr = 1'b1; rdaddr = 5'd9; win = 32'h55; raddr = {5'd9, 5'd9};
    settle_check();
    tick();
    regwr = 1'b0; iss_valid = 1'b0;
    settle_check();
    chk("simul_busy_r9", busy_vec, 64'h200);
    chk("simul_data_r9", rdata[31:0], 64'h55);
    chk("simul_rbusy_r9", rbusy[0], 64'd1);

    // Random phase on all three instances, with occasional resets.
    for (int c = 0; c < 1000; c++) begin
      int base;
      rst_n     = ($urandom_range(0, 49) != 0);
      regwr     = 1'($urandom);
      iss_valid = 1'($urandom);
      iss_rd    = 5'($urandom_range(0, 31));
      win       = $urandom;
      raddr     = 10'($urandom);
      rdaddr    = ($urandom_range(0, 3) == 0) ? raddr[4:0] : 5'($urandom_range(0, 31));
      base      = $urandom_range(0, 15);
      for (int p = 0; p < WNP; p++) w_raddr[p*WAW +: WAW] = 4'(base + p);
      w_regwr     = 1'($urandom);
      w_iss_valid = 1'($urandom);
      w_iss_rd    = 4'($urandom_range(0, 15));
      w_win       = {$urandom, $urandom};
      w_rdaddr    = ($urandom_range(0, 2) == 0) ? 4'(base + $urandom_range(0, 3))
                                                : 4'($urandom_range(0, 15));
      settle_check();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
